// File: rtl/inst_u_dec.sv
// ============================================================================
// Module   : inst_u_dec
// Purpose  : Registered RV32I U-type (LUI/AUIPC) decoder with 1-cycle latency.
//            Optional macro INST_U_DEC_STATS_EN adds per-class 32-bit counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_u_dec #(
  parameter int         XLEN         = 32,
  parameter logic [6:0] LUI_OPCODE   = 7'b0110111,
  parameter logic [6:0] AUIPC_OPCODE = 7'b0010111
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [31:0]     instruction_word,
  output logic            out_valid,
  output logic [19:0]     imm,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] imm_ext,
  output logic            is_lui,
  output logic            is_auipc,
  output logic            illegal
`ifdef INST_U_DEC_STATS_EN
  ,
  output logic [31:0]     lui_count,
  output logic [31:0]     auipc_count,
  output logic [31:0]     illegal_count
`endif
);

  logic [6:0]  w_opcode;
  logic        w_lui;
  logic        w_auipc;
  logic        w_is_u;

  logic        r_out_valid;
  logic [19:0] r_imm;
  logic [4:0]  r_rd;
  logic        r_is_lui;
  logic        r_is_auipc;
  logic        r_illegal;

  assign w_opcode = instruction_word[6:0];
  assign w_lui    = (w_opcode == LUI_OPCODE);
  assign w_auipc  = (w_opcode == AUIPC_OPCODE);
  assign w_is_u   = w_lui | w_auipc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_imm       <= 20'h00000;
      r_rd        <= 5'd0;
      r_is_lui    <= 1'b0;
      r_is_auipc  <= 1'b0;
      r_illegal   <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      // illegal is a per-cycle pulse; the decoded fields hold while idle
      r_illegal   <= 1'b0;
      if (in_valid) begin
        if (w_is_u) begin
          r_imm      <= instruction_word[31:12];
          r_rd       <= instruction_word[11:7];
          r_is_lui   <= w_lui;
          r_is_auipc <= w_auipc;
        end else begin
          r_imm      <= 20'h00000;
          r_rd       <= 5'd0;
          r_is_lui   <= 1'b0;
          r_is_auipc <= 1'b0;
          r_illegal  <= 1'b1;
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign imm       = r_imm;
  assign rd        = r_rd;
  // Only XLEN=32 is supported, so the upper immediate fills the word exactly
  assign imm_ext   = {r_imm, 12'h000};
  assign is_lui    = r_is_lui;
  assign is_auipc  = r_is_auipc;
  assign illegal   = r_illegal;

`ifdef INST_U_DEC_STATS_EN
  logic [31:0] r_lui_count;
  logic [31:0] r_auipc_count;
  logic [31:0] r_illegal_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lui_count     <= 32'd0;
      r_auipc_count   <= 32'd0;
      r_illegal_count <= 32'd0;
    end else if (in_valid) begin
      if (w_lui)   r_lui_count     <= r_lui_count + 32'd1;
      if (w_auipc) r_auipc_count   <= r_auipc_count + 32'd1;
      if (!w_is_u) r_illegal_count <= r_illegal_count + 32'd1;
    end
  end

  assign lui_count     = r_lui_count;
  assign auipc_count   = r_auipc_count;
  assign illegal_count = r_illegal_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_inst_u_dec.sv
// ============================================================================
// Module   : tb_inst_u_dec
// Purpose  : Table-driven self-checking bench for inst_u_dec.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_inst_u_dec;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] instruction_word;
  logic        out_valid;
  logic [19:0] imm;
  logic [4:0]  rd;
  logic [31:0] imm_ext;
  logic        is_lui;
  logic        is_auipc;
  logic        illegal;
`ifdef INST_U_DEC_STATS_EN
  logic [31:0] lui_count;
  logic [31:0] auipc_count;
  logic [31:0] illegal_count;
`endif

  int checks = 0;
  int errors = 0;

  inst_u_dec dut (
    .clk              (clk),
    .rst              (rst),
    .in_valid         (in_valid),
    .instruction_word (instruction_word),
    .out_valid        (out_valid),
    .imm              (imm),
    .rd               (rd),
    .imm_ext          (imm_ext),
    .is_lui           (is_lui),
    .is_auipc         (is_auipc),
    .illegal          (illegal)
`ifdef INST_U_DEC_STATS_EN
    ,
    .lui_count        (lui_count),
    .auipc_count      (auipc_count),
    .illegal_count    (illegal_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        v;
    logic [31:0] instr;
    logic        ev;
    logic [19:0] eimm;
    logic [4:0]  erd;
    logic        el;
    logic        ea;
    logic        ei;
  } vec_t;

  localparam int NVEC = 12;
  vec_t vecs [NVEC];

  localparam logic [31:0] LUI_A = 32'b00001111010101101011_01101_0110111;
  localparam logic [31:0] LUI_B = 32'b10001011010101001001_10101_0110111;

  task automatic chk(input string name, input string field,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s actual=%h required=%h", name, field, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic ev, input logic [19:0] eimm,
                         input logic [4:0] erd, input logic el, input logic ea,
                         input logic ei);
    chk(name, "out_valid", {31'd0, out_valid}, {31'd0, ev});
    chk(name, "imm",       {12'd0, imm},       {12'd0, eimm});
    chk(name, "rd",        {27'd0, rd},        {27'd0, erd});
    chk(name, "imm_ext",   imm_ext,            {eimm, 12'h000});
    chk(name, "is_lui",    {31'd0, is_lui},    {31'd0, el});
    chk(name, "is_auipc",  {31'd0, is_auipc},  {31'd0, ea});
    chk(name, "illegal",   {31'd0, illegal},   {31'd0, ei});
  endtask

  task automatic drive_cycle(input logic v, input logic [31:0] instr);
    in_valid         = v;
    instruction_word = instr;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    vecs[0]  = '{"lui_a",        1'b1, LUI_A,        1'b1, 20'h0F56B, 5'd13, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{"idle_hold",    1'b0, 32'hDEADBEEF, 1'b0, 20'h0F56B, 5'd13, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{"lui_bit31",    1'b1, LUI_B,        1'b1, 20'h8B549, 5'd21, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{"auipc",        1'b1, 32'h12345297, 1'b1, 20'h12345, 5'd5,  1'b0, 1'b1, 1'b0};
    vecs[4]  = '{"illegal_op",   1'b1, 32'h00000033, 1'b1, 20'h00000, 5'd0,  1'b0, 1'b0, 1'b1};
    vecs[5]  = '{"idle_clr_ill", 1'b0, 32'h00000033, 1'b0, 20'h00000, 5'd0,  1'b0, 1'b0, 1'b0};
    vecs[6]  = '{"lui_rd0",      1'b1, 32'hABCDE037, 1'b1, 20'hABCDE, 5'd0,  1'b1, 1'b0, 1'b0};
    vecs[7]  = '{"ill_lowbits",  1'b1, 32'h12345294, 1'b1, 20'h00000, 5'd0,  1'b0, 1'b0, 1'b1};
    vecs[8]  = '{"auipc_rd31",   1'b1, 32'hFFFFFF97, 1'b1, 20'hFFFFF, 5'd31, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{"idle_hold2",   1'b0, LUI_A,        1'b0, 20'hFFFFF, 5'd31, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{"lui_zero_imm", 1'b1, 32'h00000037, 1'b1, 20'h00000, 5'd0,  1'b1, 1'b0, 1'b0};
    vecs[11] = '{"ill_nearmiss", 1'b1, 32'hFFFFF077, 1'b1, 20'h00000, 5'd0,  1'b0, 1'b0, 1'b1};

    // Reset held over two edges with valid traffic present
    rst              = 1'b1;
    in_valid         = 1'b1;
    instruction_word = LUI_A;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk_all("reset_hold", 1'b0, 20'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    rst      = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_all("post_reset", 1'b0, 20'h0, 5'd0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < NVEC; i++) begin
      drive_cycle(vecs[i].v, vecs[i].instr);
      chk_all(vecs[i].name, vecs[i].ev, vecs[i].eimm, vecs[i].erd,
              vecs[i].el, vecs[i].ea, vecs[i].ei);
    end

    // Asynchronous clear with non-zero outputs, mid-cycle
    drive_cycle(1'b1, LUI_B);
    chk_all("pre_async", 1'b1, 20'h8B549, 5'd21, 1'b1, 1'b0, 1'b0);
    in_valid         = 1'b1;
    instruction_word = 32'h12345297;
    #1 rst = 1'b1;
    #1;
    chk_all("async_clear", 1'b0, 20'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk_all("rst_2edges", 1'b0, 20'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    rst      = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_all("dropped_inflight", 1'b0, 20'h0, 5'd0, 1'b0, 1'b0, 1'b0);

`ifdef INST_U_DEC_STATS_EN
    chk("stats_rst", "lui_count", lui_count, 32'd0);
    chk("stats_rst", "auipc_count", auipc_count, 32'd0);
    chk("stats_rst", "illegal_count", illegal_count, 32'd0);
    drive_cycle(1'b1, LUI_A);
    drive_cycle(1'b1, 32'h12345297);
    drive_cycle(1'b1, LUI_B);
    drive_cycle(1'b1, 32'h00000033);
    drive_cycle(1'b1, 32'hFFFFFF97);
    drive_cycle(1'b1, 32'hABCDE037);
    drive_cycle(1'b0, LUI_A);
    chk("stats", "lui_count", lui_count, 32'd3);
    chk("stats", "auipc_count", auipc_count, 32'd2);
    chk("stats", "illegal_count", illegal_count, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("stats_clr", "lui_count", lui_count, 32'd0);
    chk("stats_clr", "auipc_count", auipc_count, 32'd0);
    chk("stats_clr", "illegal_count", illegal_count, 32'd0);
    @(negedge clk);
    rst = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/inst_u_dec.md
Name: inst_u_dec

Overview:
- Registered decoder for RISC-V RV32I U-type instructions (LUI, AUIPC) in the instruction-decode stage.
- Extracts the 20-bit upper immediate and the destination register, classifies the opcode, and produces a pre-shifted 32-bit immediate.
- One-cycle latency, valid-qualified, for feeding the register-file write-address and ALU operand paths.

Parameters:
- XLEN, 32, datapath width of imm_ext; only the value 32 is supported.
- LUI_OPCODE, 7'b0110111, opcode recognised as LUI.
- AUIPC_OPCODE, 7'b0010111, opcode recognised as AUIPC.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  instruction_word is valid this cycle.
- instruction_word  input  32  raw instruction.
- out_valid  output  1  registered outputs are valid.
- imm  output  20  instruction_word[31:12].
- rd  output  5  instruction_word[11:7].
- imm_ext  output  XLEN  {imm, 12'b0}.
- is_lui  output  1  opcode equals LUI_OPCODE.
- is_auipc  output  1  opcode equals AUIPC_OPCODE.
- illegal  output  1  valid input whose opcode is not a U-type opcode.

Behaviour:
- Interface: one clock (clk); reset (rst) is asynchronous and active-high.
- Reset: while rst=1, every output is 0 immediately, without waiting for a clock edge. This covers out_valid, imm, rd, imm_ext, is_lui, is_auipc and illegal. First capture happens on the first rising edge after rst deasserts.
- Latency: exactly 1 cycle. Inputs sampled at rising edge N appear on the outputs after edge N.
- out_valid <= in_valid on every edge. No backpressure, no stall input. Accepts one instruction per cycle.
- Capture when in_valid=1:
  - opcode = instruction_word[6:0].
  - If opcode is LUI_OPCODE or AUIPC_OPCODE:
    - imm <= instruction_word[31:12] and rd <= instruction_word[11:7].
    - imm_ext <= {instruction_word[31:12], 12'h000}.
    - is_lui / is_auipc set per the opcode match; exactly one of them is 1; illegal <= 0.
  - Any other opcode, including bits[1:0] != 2'b11:
    - illegal <= 1, is_lui <= 0, is_auipc <= 0.
    - imm <= 0, rd <= 0, imm_ext <= 0.
- When in_valid=0:
  - out_valid <= 0.
  - imm, rd, imm_ext and the class flags hold their previous values.
  - illegal <= 0.
- No sign extension. imm_ext[31] equals instruction bit 31; the low 12 bits are always zero.
- rd=0 is a legal destination and is passed through unchanged. Writes to x0 are discarded by the register file, not by this block.
- rst asserted mid-stream: outputs clear asynchronously and the in-flight instruction is dropped. No output appears for it after reset releases.
- No combinational path from any input to any output.

Optional Feature:
- Macro: INST_U_DEC_STATS_EN.
- Defined: adds three outputs, each 32 bits:
  - lui_count, incremented on each accepted LUI.
  - auipc_count, incremented on each accepted AUIPC.
  - illegal_count, incremented on each accepted illegal opcode.
  - Each counter updates on the same edge as the corresponding output capture.
  - Each counter wraps from 32'hFFFFFFFF to 0.
  - Each counter is cleared asynchronously by rst.
- Not defined: the counter ports and logic do not exist. All other behaviour is identical.

Test Plan:
- Reset: assert rst with non-zero outputs present -> all outputs 0 before the next clock edge; hold rst over 2 edges with in_valid=1 -> outputs remain 0.
- LUI: in_valid=1, instruction_word=32'b00001111010101101011_01101_0110111 -> next cycle out_valid=1, imm=20'h0F56B, rd=13, imm_ext=32'h0F56B000, is_lui=1, is_auipc=0, illegal=0.
- LUI with bit 31 set: instruction_word=32'b10001011010101001001_10101_0110111 -> imm=20'h8B549, rd=21, imm_ext=32'h8B549000, is_lui=1.
- AUIPC then illegal, back-to-back:
  - instruction_word=32'h12345297 -> imm=20'h12345, rd=5, is_auipc=1.
  - Next instruction 32'h00000033 -> illegal=1, imm=0, rd=0, is_lui=0, is_auipc=0, out_valid=1.
- Valid gating: in_valid=0 for one cycle after the LUI case -> out_valid=0, illegal=0, imm stays 20'h0F56B and rd stays 13.
- With INST_U_DEC_STATS_EN: 3 LUI, 2 AUIPC and 1 illegal accepted, then one in_valid=0 cycle -> lui_count=3, auipc_count=2, illegal_count=1; assert rst -> all three counters 0.
